// File: rtl/wtm_pkg.sv
// rtl/wtm_pkg.sv - shared constants and state type for the row scheduler
package wtm_pkg;

  localparam int N     = 16;
  localparam int CW    = 4;
  localparam int SW    = 8;
  localparam int IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } wtm_sched_state_t;

endpackage

// File: rtl/wtm_find_first.sv
// rtl/wtm_find_first.sv - lowest-set-bit priority encoder
module wtm_find_first
  import wtm_pkg::*;
(
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // Scan from the top so the lowest set bit is the last one written.
  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) begin
        idx   = IDX_W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wtm_row_scheduler.sv
// rtl/wtm_row_scheduler.sv - issues non-zero partial-product rows to a shared reduction unit
module wtm_row_scheduler
  import wtm_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      in_x,
  input  logic [N-1:0]      in_y,
  output logic [N-1:0]      red_row,
  output logic              red_valid,
  output logic [IDX_W-1:0]  red_idx,
  input  logic [CW-1:0]     red_cnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N*CW-1:0]   out_counts,
  output logic [SW-1:0]     out_sum,
  output logic [4:0]        out_rows,
  output logic              busy
);

  wtm_sched_state_t state_q, state_d;

  logic [N-1:0]     pending_q;
  logic [N-1:0]     y_q;
  logic [N*CW-1:0]  counts_q;
  logic [SW-1:0]    sum_q;
  logic [4:0]       rows_q;

  logic [IDX_W-1:0] ff_idx;
  logic             ff_found;
  logic [N-1:0]     pending_after;
  logic [IDX_W-1:0] rest_idx;
  logic             rest_found;
  logic             accept;
  logic             run_active;

  wtm_find_first u_first (
    .vec   (pending_q),
    .idx   (ff_idx),
    .found (ff_found)
  );

  assign pending_after = pending_q & ~(N'(1) << ff_idx);

  // Nothing left after clearing the current row means this is the last RUN cycle.
  wtm_find_first u_rest (
    .vec   (pending_after),
    .idx   (rest_idx),
    .found (rest_found)
  );

  assign in_ready   = (state_q == IDLE) && !rst;
  assign accept     = in_valid && in_ready;
  assign run_active = (state_q == RUN) && ff_found && !rst;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (accept) state_d = (in_x != '0) ? RUN : DONE;
      RUN:  if (!rest_found) state_d = DONE;
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      y_q       <= '0;
      counts_q  <= '0;
      sum_q     <= '0;
      rows_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        pending_q <= in_x;
        y_q       <= in_y;
        counts_q  <= '0;
        sum_q     <= '0;
        rows_q    <= '0;
      end else if (run_active) begin
        counts_q[ff_idx*CW +: CW] <= red_cnt;
        sum_q     <= sum_q + SW'(red_cnt);
        rows_q    <= rows_q + 5'd1;
        pending_q <= pending_after;
      end
    end
  end

  // All visible outputs are forced to zero while reset is held.
  assign red_valid  = run_active;
  assign red_row    = run_active ? y_q : '0;
  assign red_idx    = run_active ? ff_idx : '0;
  assign out_valid  = (state_q == DONE) && !rst;
  assign out_counts = rst ? '0 : counts_q;
  assign out_sum    = rst ? '0 : sum_q;
  assign out_rows   = rst ? '0 : rows_q;
  assign busy       = (state_q != IDLE) && !rst;

endmodule

// File: tb/tb_wtm_row_scheduler.sv
// tb/tb_wtm_row_scheduler.sv - table-driven bench for wtm_row_scheduler
module tb_wtm_row_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic [15:0] in_y;
  logic [15:0] red_row;
  logic        red_valid;
  logic [3:0]  red_idx;
  logic [3:0]  red_cnt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_counts;
  logic [7:0]  out_sum;
  logic [4:0]  out_rows;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  wtm_row_scheduler dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_x       (in_x),
    .in_y       (in_y),
    .red_row    (red_row),
    .red_valid  (red_valid),
    .red_idx    (red_idx),
    .red_cnt    (red_cnt),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_counts (out_counts),
    .out_sum    (out_sum),
    .out_rows   (out_rows),
    .busy       (busy)
  );

  // Reduction stub: saturated popcount of the driven row.
  always_comb begin
    int pc;
    pc = $countones(red_row);
    red_cnt = (pc > 15) ? 4'd15 : 4'(pc);
  end

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic [63:0] counts;
    logic [7:0]  sum;
    logic [4:0]  rows;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int v);
    int   w;
    int   lat;
    int   ptr;
    int   issued;
    bit   done;
    int   e;
    bit   ef;
    @(negedge clk);
    w = 0;
    while (!in_ready && w < 10) begin
      @(negedge clk);
      w++;
    end
    check("in_ready_idle", in_ready, 1);
    in_x     = vecs[v].x;
    in_y     = vecs[v].y;
    in_valid = 1'b1;
    lat = 0; ptr = 0; issued = 0; done = 0;
    while (!done && lat < 40) begin
      @(posedge clk);
      #1;
      if (lat == 0) in_valid = 1'b0;
      lat++;
      if (red_valid) begin
        ef = 0; e = 0;
        for (int b = 15; b >= ptr; b--) begin
          if (vecs[v].x[b]) begin
            e = b; ef = 1;
          end
        end
        if (!ef) check("red_extra_issue", 1, 0);
        else begin
          check("red_idx", red_idx, e);
          check("red_row", red_row, vecs[v].y);
          ptr = e + 1;
        end
        issued++;
      end
      if (out_valid) done = 1;
    end
    check("out_valid_seen", done, 1);
    check("latency", lat, vecs[v].lat);
    check("out_counts", out_counts, vecs[v].counts);
    check("out_sum", out_sum, vecs[v].sum);
    check("out_rows", out_rows, vecs[v].rows);
    check("issued_rows", issued, vecs[v].rows);
    check("in_ready_done", in_ready, 0);
    check("busy_done", busy, 1);
  endtask

  task automatic drain(input logic [7:0] exp_sum);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("in_ready_after_drain", in_ready, 1);
    check("out_valid_after_drain", out_valid, 0);
    check("busy_after_drain", busy, 0);
    check("sum_held_idle", out_sum, exp_sum);
  endtask

  initial begin
    logic [63:0] hc;
    logic [7:0]  hs;
    logic [4:0]  hr;

    vecs[0] = '{16'h0001, 16'h00FF, 64'h0000_0000_0000_0008, 8'd8,   5'd1,  2};
    vecs[1] = '{16'h0000, 16'hFFFF, 64'h0000_0000_0000_0000, 8'd0,   5'd0,  1};
    vecs[2] = '{16'hFFFF, 16'hFFFF, 64'hFFFF_FFFF_FFFF_FFFF, 8'd240, 5'd16, 17};
    vecs[3] = '{16'h8001, 16'h0F0F, 64'h8000_0000_0000_0008, 8'd16,  5'd2,  3};
    vecs[4] = '{16'h0104, 16'h0003, 64'h0000_0002_0000_0200, 8'd4,   5'd2,  3};

    rst = 1'b1; in_valid = 1'b0; in_x = '0; in_y = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_red_valid", red_valid, 0);
    check("rst_red_row", red_row, 0);
    check("rst_red_idx", red_idx, 0);
    check("rst_out_counts", out_counts, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_rows", out_rows, 0);
    check("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", in_ready, 1);

    for (int v = 0; v < 5; v++) begin
      run_vec(v);
      drain(vecs[v].sum);
    end

    // Backpressure in DONE with a competing operand pair on the input.
    run_vec(3);
    hc = out_counts; hs = out_sum; hr = out_rows;
    @(negedge clk);
    in_x = vecs[0].x; in_y = vecs[0].y; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_counts", out_counts, hc);
      check("hold_sum", out_sum, hs);
      check("hold_rows", out_rows, hr);
    end
    drain(hs);
    run_vec(0);
    drain(vecs[0].sum);

    // Reset during the fourth RUN cycle of a full-width operation.
    @(negedge clk);
    in_x = 16'hFFFF; in_y = 16'hFFFF; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("abort_red_idx", red_idx, 3);
    check("abort_red_valid", red_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("abort_rst_red_valid", red_valid, 0);
    check("abort_rst_busy", busy, 0);
    check("abort_rst_in_ready", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_idle_in_ready", in_ready, 1);
    check("abort_idle_busy", busy, 0);
    check("abort_idle_red_valid", red_valid, 0);
    check("abort_idle_out_valid", out_valid, 0);
    check("abort_idle_counts", out_counts, 0);
    check("abort_idle_sum", out_sum, 0);
    check("abort_idle_rows", out_rows, 0);
    run_vec(0);
    drain(vecs[0].sum);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
